// File: rtl/taillight_ctrl.sv
// taillight_ctrl: request controller for the Thunderbird taillight sequencer.
// Debounces the raw left/right/hazard switches and arbitrates them into one
// mode. A mode is held for a whole lamp frame. The sequencer advances on the
// one-cycle step strobe.
module taillight_ctrl #(
    parameter int DIV = 4,
    parameter int DB  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_sw,
    input  logic       right_sw,
    input  logic       hazard_sw,
    output logic       left,
    output logic       right,
    output logic       hazard,
    output logic       step,
    output logic [1:0] mode,
    output logic       busy
);

    localparam int CW = $clog2(DB + 1);
    localparam int PW = $clog2(DIV);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } state_t;

    // Bit order for the switch vectors: [0] left, [1] right, [2] hazard.
    logic [2:0]    raw;
    logic [2:0]    sw_s;
    logic [2:0]    sw_f;
    logic [CW-1:0] db_cnt [3];

    state_t        req;
    state_t        state_q;
    state_t        state_d;
    logic [PW-1:0] pc_q;
    logic [PW-1:0] pc_d;
    logic [1:0]    fi_q;
    logic [1:0]    fi_d;
    logic [1:0]    last_fi;

    assign raw = {hazard_sw, right_sw, left_sw};

    // Sample each raw switch once, then accept a new level only after it has
    // differed from the filtered value for DB consecutive samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s <= '0;
            sw_f <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sw_s <= raw;
            for (int i = 0; i < 3; i++) begin
                if (sw_s[i] != sw_f[i]) begin
                    if (db_cnt[i] == CW'(DB - 1)) begin
                        sw_f[i]   <= sw_s[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Priority arbitration of the filtered switches; left+right together is a conflict and becomes hazard.
    always_comb begin
        req = IDLE;
        if (sw_f[2]) begin
            req = HAZARD;
        end else if (sw_f[0] && sw_f[1]) begin
            req = HAZARD;
        end else if (sw_f[0]) begin
            req = LEFT;
        end else if (sw_f[1]) begin
            req = RIGHT;
        end
    end

    // State, prescaler and frame index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fi_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fi_q    <= fi_d;
        end
    end

    // Next-state and step strobe: requests are only taken in IDLE or at the last step of a frame.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fi_d    = fi_q;
        step    = 1'b0;
        last_fi = (state_q == HAZARD) ? 2'd1 : 2'd3;
        if (state_q == IDLE) begin
            state_d = req;
            pc_d    = '0;
            fi_d    = '0;
        end else if (pc_q == PW'(DIV - 1)) begin
            step = 1'b1;
            pc_d = '0;
            if (fi_q == last_fi) begin
                state_d = req;
                fi_d    = '0;
            end else begin
                fi_d = fi_q + 2'd1;
            end
        end else begin
            pc_d = pc_q + PW'(1);
        end
    end

    assign left   = (state_q == LEFT);
    assign right  = (state_q == RIGHT);
    assign hazard = (state_q == HAZARD);
    assign mode   = state_q;
    assign busy   = |mode;

endmodule

// File: tb/tb_taillight_ctrl.sv
// tb_taillight_ctrl: directed checks of the taillight request controller.
// Instance u_dut uses the default DIV=4/DB=3; u_min uses DIV=2/DB=1.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_taillight_ctrl;

    logic       clk;
    logic       rst_n;
    logic       left_sw;
    logic       right_sw;
    logic       hazard_sw;

    logic       l1, r1, h1, st1, b1;
    logic [1:0] m1;
    logic       l2, r2, h2, st2, b2;
    logic [1:0] m2;

    int errors;
    int checks;

    taillight_ctrl #(.DIV(4), .DB(3)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .left_sw   (left_sw),
        .right_sw  (right_sw),
        .hazard_sw (hazard_sw),
        .left      (l1),
        .right     (r1),
        .hazard    (h1),
        .step      (st1),
        .mode      (m1),
        .busy      (b1)
    );

    taillight_ctrl #(.DIV(2), .DB(1)) u_min (
        .clk       (clk),
        .rst_n     (rst_n),
        .left_sw   (left_sw),
        .right_sw  (right_sw),
        .hazard_sw (hazard_sw),
        .left      (l2),
        .right     (r2),
        .hazard    (h2),
        .step      (st2),
        .mode      (m2),
        .busy      (b2)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic l, input logic r, input logic h);
        left_sw   = l;
        right_sw  = r;
        hazard_sw = h;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Directed test sequence.
    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("reset_left", l1, 0);
        checkOutput("reset_mode", m1, 0);
        checkOutput("reset_busy", b1, 0);
        checkOutput("reset_step", st1, 0);
        checkOutput("reset_min_step", st2, 0);
        checkOutput("reset_min_mode", m2, 0);

        // Turn sweep: left enters E0+4, steps every 4 cycles, frames back to back.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        checkOutput("sweep_pre_left", l1, 0);
        checkOutput("sweep_pre_mode", m1, 0);
        tick();
        checkOutput("sweep_left", l1, 1);
        checkOutput("sweep_mode", m1, 1);
        checkOutput("sweep_busy", b1, 1);
        checkOutput("sweep_step0", st1, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            checkOutput($sformatf("sweep_step_n%0d", n), st1, (n % 4 == 3) ? 1 : 0);
            checkOutput($sformatf("sweep_mode_n%0d", n), m1, 1);
        end

        // Request drop after step 1: frame completes, then IDLE with no more steps.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        for (int n = 1; n <= 24; n++) begin
            tick();
            checkOutput($sformatf("drop_mode_n%0d", n), m1, (n < 16) ? 1 : 0);
            checkOutput($sformatf("drop_busy_n%0d", n), b1, (n < 16) ? 1 : 0);
            checkOutput($sformatf("drop_step_n%0d", n), st1, (n < 16 && n % 4 == 3) ? 1 : 0);
            if (n == 3) applyStimulus(1'b0, 1'b0, 1'b0);
        end

        // Left and right together is treated as hazard; hazard frame is 2 steps.
        applyReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("conflict_mode", m1, 3);
        checkOutput("conflict_hazard", h1, 1);
        checkOutput("conflict_left", l1, 0);
        checkOutput("conflict_right", r1, 0);
        for (int n = 1; n <= 12; n++) begin
            tick();
            checkOutput($sformatf("conflict_step_n%0d", n), st1, (n % 4 == 3) ? 1 : 0);
            checkOutput($sformatf("conflict_mode_n%0d", n), m1, 3);
        end

        // Hazard raised during a LEFT frame only takes over at the frame end.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (5) tick();
        for (int n = 1; n <= 20; n++) begin
            tick();
            checkOutput($sformatf("hzl_mode_n%0d", n), m1, (n < 16) ? 1 : 3);
            checkOutput($sformatf("hzl_step_n%0d", n), st1, (n % 4 == 3) ? 1 : 0);
            if (n == 16) begin
                checkOutput("hzl_hazard", h1, 1);
                checkOutput("hzl_left", l1, 0);
            end
            if (n == 1) applyStimulus(1'b1, 1'b0, 1'b1);
        end

        // Debounce: a 2-sample pulse is rejected, a 3-sample pulse is accepted.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int n = 1; n <= 8; n++) begin
            tick();
            checkOutput($sformatf("bounce2_mode_n%0d", n), m1, 0);
        end
        checkOutput("bounce2_left", l1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (3) tick();
        applyStimulus(1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("bounce3_pre_left", l1, 0);
        tick();
        checkOutput("bounce3_left", l1, 1);
        checkOutput("bounce3_mode", m1, 1);

        // Asynchronous reset in the middle of a RIGHT frame, then re-entry.
        applyReset();
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (5) tick();
        checkOutput("rstmid_right_before", r1, 1);
        checkOutput("rstmid_mode_before", m1, 2);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_right", r1, 0);
        checkOutput("rstmid_step", st1, 0);
        checkOutput("rstmid_busy", b1, 0);
        checkOutput("rstmid_mode", m1, 0);
        tick();
        tick();
        checkOutput("rstmid_hold_mode", m1, 0);
        rst_n = 1'b1;
        repeat (4) tick();
        checkOutput("rstmid_pre_right", r1, 0);
        tick();
        checkOutput("rstmid_reenter_right", r1, 1);
        checkOutput("rstmid_reenter_mode", m1, 2);
        for (int n = 1; n <= 4; n++) begin
            tick();
            checkOutput($sformatf("rstmid_step_n%0d", n), st1, (n == 3) ? 1 : 0);
        end

        // Minimum divider instance: step every 2 cycles, 8-cycle LEFT frame.
        applyReset();
        applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (2) tick();
        checkOutput("min_pre_left", l2, 0);
        tick();
        checkOutput("min_left", l2, 1);
        checkOutput("min_mode", m2, 1);
        for (int n = 1; n <= 10; n++) begin
            tick();
            checkOutput($sformatf("min_step_n%0d", n), st2, (n % 2 == 1) ? 1 : 0);
            checkOutput($sformatf("min_mode_n%0d", n), m2, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
